instr_encoder: RTL and testbench

- Packs instruction fields (opcode, addressing mode, register indices, data/instruction memory addresses) into 16-bit instruction words.
- Writes the packed words sequentially into instruction memory.
- It is the inverse of the instruction decoder and acts as the program loader between a host/assembler stream and instruction memory.
- One encoded word is written per accepted field set, over a valid/ready handshake.

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Program loader: packs instruction fields into 16-bit words and writes them
// sequentially into instruction memory, one word per accepted field set.
module instr_encoder #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic              addressing_mode,
  input  logic [2:0]        reg1,
  input  logic [2:0]        reg2,
  input  logic [2:0]        reg3,
  input  logic [4:0]        data_mem,
  input  logic [4:0]        instruction_mem,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_we;
  logic              r_ovf;

  logic              w_full;
  logic              w_in_load;
  logic              w_open;
  logic              w_restart;
  logic              w_xfer;
  logic              w_ovf_hit;
  logic [15:0]       w_word;

  assign w_full    = (r_count == FULL_COUNT);
  assign w_in_load = (r_state == S_LOAD);
  assign w_open    = (r_state == S_IDLE) && start;
  assign w_restart = w_in_load && start;
  // A start in LOAD takes priority: any field set offered alongside it is dropped.
  assign w_xfer    = w_in_load && !start && in_valid && !w_full;
  assign w_ovf_hit = w_in_load && !start && in_valid && w_full;

  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_word          = '0;
    w_word[15:12]   = opcode;
    w_word[11]      = addressing_mode;
    if (opcode[3:2] == 2'b11) begin
      w_word[4:0]   = instruction_mem;
    end else if (!addressing_mode) begin
      w_word[10:8]  = reg1;
      w_word[7:5]   = reg2;
      w_word[4:2]   = reg3;
    end else begin
      w_word[10:8]  = reg1;
      w_word[7:3]   = data_mem;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = !w_full;
        busy     = 1'b1;
        if (w_xfer && in_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_we <= w_xfer;
      if (w_open || w_restart) begin
        r_count <= '0;
        r_ptr   <= '0;
        r_ovf   <= 1'b0;
      end else if (w_xfer) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_count <= r_count + 1'b1;
        // Pointer saturates at the last slot rather than wrapping over word 0.
        if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + 1'b1;
      end else if (w_ovf_hit) begin
        r_ovf   <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign overflow   = r_ovf;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: fixed vectors, hand-written corner
// sequences and a randomized run against a behavioural session model.
module tb_instr_encoder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef struct packed {
    logic [3:0] op;
    logic       mode;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] r3;
    logic [4:0] dm;
    logic [4:0] im;
  } fields_t;

  typedef struct {
    fields_t     f;
    logic [15:0] word;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, in_valid, in_ready, in_last;
  logic [3:0]        opcode;
  logic              addressing_mode;
  logic [2:0]        reg1, reg2, reg3;
  logic [4:0]        data_mem, instruction_mem;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              busy, done, overflow;
  logic [ADDR_W:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0 = idle, 1 = loading, 2 = finishing.
  int m_phase, m_count, m_addr, m_wdata;
  bit m_we, m_ovf;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .opcode(opcode),
    .addressing_mode(addressing_mode), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .data_mem(data_mem), .instruction_mem(instruction_mem),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_word(input fields_t f);
    int w;
    w = f.op * 4096 + f.mode * 2048;
    if (f.op / 4 == 3)  w += f.im;
    else if (f.mode == 0) w += f.r1 * 256 + f.r2 * 32 + f.r3 * 4;
    else                w += f.r1 * 256 + f.dm * 8;
    return w;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_count = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit st, input bit v, input bit l, input fields_t f);
    m_we = 0;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_count = 0; m_ovf = 0; end
      1: begin
        if (st) begin
          m_count = 0; m_ovf = 0;
        end else if (v && m_count < DEPTH) begin
          m_we = 1; m_addr = m_count; m_wdata = ref_word(f);
          m_count++;
          if (l) m_phase = 2;
        end else if (v) begin
          m_ovf = 1;
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic compare_all();
    check("imem_we", imem_we, m_we);
    if (m_we) begin
      check("imem_addr", imem_addr, m_addr);
      check("imem_wdata", imem_wdata, m_wdata);
    end
    check("busy", busy, m_phase != 0);
    check("done", done, m_phase == 2);
    check("overflow", overflow, m_ovf);
    check("count", count, m_count);
    check("in_ready", in_ready, (m_phase == 1) && (m_count < DEPTH));
  endtask

  task automatic drive(input bit st, input bit v, input bit l, input fields_t f);
    start = st; in_valid = v; in_last = l;
    opcode = f.op; addressing_mode = f.mode;
    reg1 = f.r1; reg2 = f.r2; reg3 = f.r3;
    data_mem = f.dm; instruction_mem = f.im;
    model_edge(st, v, l, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic fields_t rand_fields();
    logic [31:0] rv;
    rv = $urandom;
    return rv[23:0];
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_ready"}, in_ready, 0);
  endtask

  vec_t    vecs[6];
  fields_t idle_f;

  initial begin
    idle_f = '0;
    vecs[0] = '{f: '{op:4'b0001, mode:1'b0, r1:3'b011, r2:3'b001, r3:3'b100, dm:5'd9,  im:5'd3},  word:16'h1330};
    vecs[1] = '{f: '{op:4'b0101, mode:1'b1, r1:3'b110, r2:3'b111, r3:3'b111, dm:5'b01100, im:5'd31}, word:16'h5E60};
    vecs[2] = '{f: '{op:4'b1100, mode:1'b0, r1:3'b111, r2:3'b101, r3:3'b011, dm:5'd31, im:5'b10101}, word:16'hC015};
    vecs[3] = '{f: '{op:4'b1111, mode:1'b1, r1:3'b111, r2:3'b111, r3:3'b111, dm:5'd31, im:5'b11111}, word:16'hF81F};
    vecs[4] = '{f: '{op:4'b1011, mode:1'b0, r1:3'b111, r2:3'b111, r3:3'b111, dm:5'd0,  im:5'd31},  word:16'hB7FC};
    vecs[5] = '{f: '{op:4'b0000, mode:1'b1, r1:3'b000, r2:3'b111, r3:3'b111, dm:5'b11111, im:5'd31}, word:16'h08F8};

    rst_n = 1'b0;
    start = 0; in_valid = 0; in_last = 0;
    opcode = 0; addressing_mode = 0; reg1 = 0; reg2 = 0; reg3 = 0;
    data_mem = 0; instruction_mem = 0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed encoding vectors streamed as one session, in_last on the final one.
    drive(1, 0, 0, idle_f);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, i == 5, vecs[i].f);
      check("tbl_we", imem_we, 1);
      check("tbl_addr", imem_addr, i);
      check("tbl_word", imem_wdata, vecs[i].word);
    end
    check("tbl_done", done, 1);
    check("tbl_count", count, 6);
    drive(0, 0, 0, idle_f);
    check("tbl_busy_fall", busy, 0);
    check("tbl_count_hold", count, 6);

    // Three-word stream with a gap-free handshake.
    drive(1, 0, 0, idle_f);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 2, rand_fields());
      check("s3_addr", imem_addr, i);
    end
    check("s3_done", done, 1);
    drive(0, 0, 0, idle_f);
    check("s3_done_pulse", done, 0);

    // Fill memory, then offer one more word.
    drive(1, 0, 0, idle_f);
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, rand_fields());
    check("fill_addr", imem_addr, DEPTH - 1);
    check("fill_count", count, DEPTH);
    check("fill_ready", in_ready, 0);
    drive(0, 1, 1, rand_fields());
    check("ovf_no_we", imem_we, 0);
    check("ovf_set", overflow, 1);
    drive(0, 0, 0, idle_f);
    check("ovf_sticky", overflow, 1);
    drive(1, 0, 0, idle_f);
    check("ovf_clear", overflow, 0);
    check("restart_count", count, 0);

    // start with a valid transfer in LOAD: transfer dropped, session restarts.
    drive(0, 1, 0, rand_fields());
    drive(0, 1, 0, rand_fields());
    drive(1, 1, 1, rand_fields());
    check("rs_drop_we", imem_we, 0);
    check("rs_count", count, 0);
    check("rs_no_done", done, 0);
    drive(0, 1, 0, rand_fields());
    check("rs_addr0", imem_addr, 0);

    // start during FLUSH is ignored.
    drive(0, 1, 1, rand_fields());
    drive(1, 0, 0, idle_f);
    check("fl_start_ignored", busy, 0);

    // Asynchronous reset mid-stream after five words.
    drive(1, 0, 0, idle_f);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, rand_fields());
    check("pre_rst_count", count, 5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, idle_f);
    drive(0, 1, 0, rand_fields());
    check("post_rst_addr", imem_addr, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bit st, v, l;
      st = ($urandom_range(0, 63) == 0);
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 39) == 0);
      if (m_phase == 0 && $urandom_range(0, 3) == 0) st = 1;
      drive(st, v, l, rand_fields());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
